// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB pipeline register: WB control bit
// positions, elastic-buffer state encoding and the default-width payload view.
package mem_wb_pkg;

    localparam int unsigned WB_MEMTOREG = 1;
    localparam int unsigned WB_REGWRITE = 0;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF  = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    // Payload layout at default widths; field order matches the flat packing in the top.
    typedef struct packed {
        logic                  memtoreg;
        logic                  regwrite;
        logic [DATA_W_DEF-1:0] memdata;
        logic [DATA_W_DEF-1:0] alu;
        logic [ADDR_W_DEF-1:0] rd;
    } mem_wb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic elastic register on a flat payload.
// SKID=1: head + skid entry, in_ready from a register (no path from out_ready).
// SKID=0: single entry, in_ready = !out_valid | out_ready.
module pipe_skid_buf
    import mem_wb_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned SKID = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         accept;
    logic         retire;

    // Handshake decode; both transfers resolve on the same edge.
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;
    assign occupancy = 2'(state_q);
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    // Next-state and payload steering; flush overrides any accept.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && retire) begin
                    head_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = TWO;
                end else if (retire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (retire) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != TWO);
    end

    // State, registered ready and payload registers (payload reset only for clean traces).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: rtl/mem_wb_elastic_reg.sv
// MEM/WB pipeline register with valid/ready handshake, stall absorption and
// flush; also drives the writeback mux and register-file write enable.
module mem_wb_elastic_reg
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_wb,
    input  logic [DATA_W-1:0] in_memdata,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [ADDR_W-1:0] in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_memtoreg,
    output logic              out_regwrite,
    output logic [DATA_W-1:0] out_memdata,
    output logic [DATA_W-1:0] out_alu,
    output logic [ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [1:0]        occupancy
);

    localparam int unsigned PAYLOAD_W = 2 + 2 * DATA_W + ADDR_W;

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    // Flatten the stage payload: {memtoreg, regwrite, memdata, alu, rd}.
    assign in_payload = {in_wb[1'(WB_MEMTOREG)], in_wb[1'(WB_REGWRITE)],
                         in_memdata, in_alu, in_rd};

    pipe_skid_buf #(
        .W    (PAYLOAD_W),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload),
        .occupancy (occupancy)
    );

    assign {out_memtoreg, out_regwrite, out_memdata, out_alu, out_rd} = out_payload;

    // Writeback select and write enable; a stale RegWrite never writes when invalid, and r0 is never written.
    assign wb_data = out_memtoreg ? out_memdata : out_alu;
    assign wb_we   = out_valid && out_ready && out_regwrite && (out_rd != '0);

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Scoreboard bench: index 0 is the SKID=1 instance, index 1 the SKID=0
// instance; both share the same input stimulus.
module tb_mem_wb_elastic_reg;
    import mem_wb_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  in_wb;
    logic [31:0] in_memdata;
    logic [31:0] in_alu;
    logic [4:0]  in_rd;

    logic        in_ready     [2];
    logic        out_valid    [2];
    logic        out_memtoreg [2];
    logic        out_regwrite [2];
    logic [31:0] out_memdata  [2];
    logic [31:0] out_alu      [2];
    logic [4:0]  out_rd       [2];
    logic [31:0] wb_data      [2];
    logic        wb_we        [2];
    logic [1:0]  occupancy    [2];

    mem_wb_payload_t sbq [2][$];
    int n_cmp;
    int n_fail;
    int acc_cnt [2];
    int ret_cnt [2];
    bit mon_en;

    mem_wb_elastic_reg #(.DATA_W(32), .ADDR_W(5), .SKID(1)) u_skid1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_wb(in_wb), .in_memdata(in_memdata), .in_alu(in_alu), .in_rd(in_rd),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_memtoreg(out_memtoreg[0]),
        .out_regwrite(out_regwrite[0]), .out_memdata(out_memdata[0]), .out_alu(out_alu[0]),
        .out_rd(out_rd[0]), .wb_data(wb_data[0]), .wb_we(wb_we[0]), .occupancy(occupancy[0])
    );

    mem_wb_elastic_reg #(.DATA_W(32), .ADDR_W(5), .SKID(0)) u_skid0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_wb(in_wb), .in_memdata(in_memdata), .in_alu(in_alu), .in_rd(in_rd),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_memtoreg(out_memtoreg[1]),
        .out_regwrite(out_regwrite[1]), .out_memdata(out_memdata[1]), .out_alu(out_alu[1]),
        .out_rd(out_rd[1]), .wb_data(wb_data[1]), .wb_we(wb_we[1]), .occupancy(occupancy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d): actual=0x%08h required=0x%08h at t=%0t", name, inst, act, exp, $time);
        end
    endtask

    function automatic mem_wb_payload_t mk(input logic [1:0] wb, input logic [31:0] md,
                                           input logic [31:0] alu, input logic [4:0] rd);
        mem_wb_payload_t p;
        p.memtoreg = wb[1];
        p.regwrite = wb[0];
        p.memdata  = md;
        p.alu      = alu;
        p.rd       = rd;
        return p;
    endfunction

    function automatic mem_wb_payload_t rnd_p();
        return mk(2'($urandom), $urandom, $urandom, 5'($urandom_range(0, 31)));
    endfunction

    // Monitor: compare each DUT's head against the front of its reference FIFO.
    task automatic mon(input int i);
        mem_wb_payload_t h;
        int sz;
        sz = sbq[i].size();
        chk("occupancy", i, 32'(occupancy[i]), 32'(sz));
        chk("out_valid", i, 32'(out_valid[i]), 32'(sz != 0));
        if (i == 0) chk("in_ready_skid", i, 32'(in_ready[i]), 32'(sz < 2));
        else        chk("in_ready_comb", i, 32'(in_ready[i]), 32'((sz == 0) || out_ready));
        if (sz != 0) begin
            h = sbq[i][0];
            chk("out_memtoreg", i, 32'(out_memtoreg[i]), 32'(h.memtoreg));
            chk("out_regwrite", i, 32'(out_regwrite[i]), 32'(h.regwrite));
            chk("out_memdata", i, out_memdata[i], h.memdata);
            chk("out_alu", i, out_alu[i], h.alu);
            chk("out_rd", i, 32'(out_rd[i]), 32'(h.rd));
            chk("wb_data", i, wb_data[i], h.memtoreg ? h.memdata : h.alu);
            chk("wb_we", i, 32'(wb_we[i]), 32'(out_ready && h.regwrite && (h.rd != 5'd0)));
            if (out_ready) begin
                void'(sbq[i].pop_front());
                ret_cnt[i]++;
            end
        end else begin
            chk("wb_we_idle", i, 32'(wb_we[i]), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            mon(0);
            mon(1);
        end
    end

    // One stimulus cycle; expected entries are pushed once the handshake is known.
    task automatic cyc(input bit v, input bit ordy, input bit fl, input mem_wb_payload_t p);
        @(posedge clk);
        #2;
        in_valid   = v;
        out_ready  = ordy;
        flush      = fl;
        in_wb      = {p.memtoreg, p.regwrite};
        in_memdata = p.memdata;
        in_alu     = p.alu;
        in_rd      = p.rd;
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (fl) begin
                sbq[i].delete();
            end else if (v && in_ready[i]) begin
                sbq[i].push_back(p);
                acc_cnt[i]++;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_out_valid"}, i, 32'(out_valid[i]), 32'd0);
            chk({tag, "_occupancy"}, i, 32'(occupancy[i]), 32'd0);
            chk({tag, "_out_memdata"}, i, out_memdata[i], 32'd0);
            chk({tag, "_out_alu"}, i, out_alu[i], 32'd0);
            chk({tag, "_out_rd"}, i, 32'(out_rd[i]), 32'd0);
            chk({tag, "_out_wbctl"}, i, 32'({out_memtoreg[i], out_regwrite[i]}), 32'd0);
            chk({tag, "_wb_data"}, i, wb_data[i], 32'd0);
            chk({tag, "_wb_we"}, i, 32'(wb_we[i]), 32'd0);
        end
        chk({tag, "_in_ready"}, 0, 32'(in_ready[0]), 32'd0);
    endtask

    task automatic release_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("in_ready_after_rst", 0, 32'(in_ready[0]), 32'd1);
        chk("in_ready_after_rst", 1, 32'(in_ready[1]), 32'd1);
        mon_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_wb_payload_t pa, pb, pc, e1, e2, e3, pn, idle;
        int s_acc, s_ret;
        n_cmp = 0; n_fail = 0; mon_en = 1'b0;
        acc_cnt[0] = 0; acc_cnt[1] = 0; ret_cnt[0] = 0; ret_cnt[1] = 0;
        idle = mk(2'b00, 32'd0, 32'd0, 5'd0);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_wb = 2'b00; in_memdata = '0; in_alu = '0; in_rd = '0;
        #3;
        chk_reset_vals("reset");
        release_reset();

        // Stream: back-to-back entries at full throughput.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0, rnd_p());
            if (k > 0) begin
                chk("stream_occ", 0, 32'(occupancy[0]), 32'd1);
                chk("stream_in_ready", 0, 32'(in_ready[0]), 32'd1);
            end
        end

        // Writeback mux and write enable.
        e1 = mk(2'b11, 32'hDEADBEEF, 32'h0000_1234, 5'd7);
        e2 = mk(2'b01, 32'hDEADBEEF, 32'h0000_1234, 5'd7);
        e3 = mk(2'b11, 32'hDEADBEEF, 32'h0000_1234, 5'd0);
        cyc(1'b1, 1'b1, 1'b0, e1);
        cyc(1'b1, 1'b1, 1'b0, e2);
        chk("wbmux_mem_data", 0, wb_data[0], 32'hDEADBEEF);
        chk("wbmux_mem_we", 0, 32'(wb_we[0]), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, e3);
        chk("wbmux_alu_data", 0, wb_data[0], 32'h0000_1234);
        chk("wbmux_alu_we", 0, 32'(wb_we[0]), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, idle);
        chk("wbmux_rd0_we", 0, 32'(wb_we[0]), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, idle);

        // Stall: third entry must be held upstream, then drain in order.
        pa = rnd_p(); pb = rnd_p(); pc = rnd_p();
        cyc(1'b1, 1'b0, 1'b0, pa);
        cyc(1'b1, 1'b0, 1'b0, pb);
        chk("stall_occ_one", 0, 32'(occupancy[0]), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, pc);
        chk("stall_occ_two", 0, 32'(occupancy[0]), 32'd2);
        chk("stall_in_ready", 0, 32'(in_ready[0]), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, idle);
        chk("drain_first", 0, out_memdata[0], pa.memdata);
        cyc(1'b0, 1'b1, 1'b0, idle);
        chk("drain_second", 0, out_memdata[0], pb.memdata);
        cyc(1'b0, 1'b1, 1'b0, idle);
        chk("drain_empty", 0, 32'(out_valid[0]), 32'd0);

        // Flush while full, with a simultaneous valid input.
        cyc(1'b1, 1'b0, 1'b0, rnd_p());
        cyc(1'b1, 1'b0, 1'b0, rnd_p());
        cyc(1'b1, 1'b0, 1'b1, mk(2'b11, 32'h1111_1111, 32'h2222_2222, 5'd3));
        pn = mk(2'b01, 32'hCAFE_0000, 32'h0BAD_F00D, 5'd9);
        cyc(1'b1, 1'b1, 1'b0, pn);
        chk("flush_out_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("flush_occ", 0, 32'(occupancy[0]), 32'd0);
        chk("flush_wb_we", 0, 32'(wb_we[0]), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, idle);
        chk("post_flush_valid", 0, 32'(out_valid[0]), 32'd1);
        chk("post_flush_alu", 0, out_alu[0], pn.alu);

        // Asynchronous reset while holding two entries.
        cyc(1'b1, 1'b0, 1'b0, rnd_p());
        cyc(1'b1, 1'b0, 1'b0, rnd_p());
        cyc(1'b0, 1'b0, 1'b0, idle);
        chk("pre_rst_occ", 0, 32'(occupancy[0]), 32'd2);
        #1;
        rst = 1'b1;
        mon_en = 1'b0;
        sbq[0].delete();
        sbq[1].delete();
        #1;
        chk_reset_vals("async_rst");
        release_reset();

        // SKID=0: out_ready toggles every cycle over 20 accepted entries.
        s_acc = acc_cnt[1];
        s_ret = ret_cnt[1];
        for (int k = 0; k < 200 && (acc_cnt[1] - s_acc) < 20; k++) begin
            cyc(1'b1, (k % 2) == 0, 1'b0, rnd_p());
        end
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, idle);
        chk("skid0_accepted", 1, 32'(acc_cnt[1] - s_acc), 32'd20);
        chk("skid0_retired", 1, 32'(ret_cnt[1] - s_ret), 32'd20);

        // Randomised traffic with occasional flushes.
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0, rnd_p());
        end
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, idle);
        chk("final_empty", 0, 32'(out_valid[0]), 32'd0);
        chk("final_empty", 1, 32'(out_valid[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
